// File: rtl/dm_arbiter.sv
// Round-robin two-port arbiter in front of a single-port data memory, with bounded burst lock.
// Optional grant/wait performance counters are enabled with DM_ARB_PERF_EN.
module dm_arbiter #(
    parameter int AW        = 7,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_wr,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          a_lock,
    output logic          a_gnt,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_wr,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    input  logic          b_lock,
    output logic          b_gnt,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] m_addr,
    output logic          m_rd,
    output logic          m_wr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
`ifdef DM_ARB_PERF_EN
    ,
    output logic [15:0]   a_gnt_cnt,
    output logic [15:0]   b_gnt_cnt,
    output logic [15:0]   wait_cnt
`endif
);
    localparam int BCW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t         state;
    logic           last;        // 1 = B was granted most recently
    logic [BCW-1:0] burst_cnt;
    logic           lock_q;      // owner asked to keep ownership at its last grant
    logic           lock_a;
    logic           lock_b;

    always_comb begin
        a_gnt  = 1'b0;
        b_gnt  = 1'b0;
        lock_a = (state == OWN_A) && lock_q && (burst_cnt < BCW'(MAX_BURST));
        lock_b = (state == OWN_B) && lock_q && (burst_cnt < BCW'(MAX_BURST));
        if (rst_n) begin
            if (a_req && b_req) begin
                if (lock_a)      a_gnt = 1'b1;
                else if (lock_b) b_gnt = 1'b1;
                else if (last)   a_gnt = 1'b1;
                else             b_gnt = 1'b1;
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    always_comb begin
        m_addr  = '0;
        m_wdata = '0;
        if (a_gnt) begin
            m_addr  = a_addr;
            m_wdata = a_wdata;
        end else if (b_gnt) begin
            m_addr  = b_addr;
            m_wdata = b_wdata;
        end
        m_rd = (a_gnt & ~a_wr) | (b_gnt & ~b_wr);
        m_wr = (a_gnt & a_wr) | (b_gnt & b_wr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= '0;
            lock_q    <= 1'b0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            a_ack <= a_gnt;
            b_ack <= b_gnt;
            if (a_gnt) a_rdata <= m_rdata;
            if (b_gnt) b_rdata <= m_rdata;
            if (a_gnt || b_gnt) begin
                if ((a_gnt && state == OWN_A) || (b_gnt && state == OWN_B)) begin
                    if (burst_cnt < BCW'(MAX_BURST))
                        burst_cnt <= burst_cnt + 1'b1;
                end else begin
                    burst_cnt <= BCW'(1);
                end
                state  <= a_gnt ? OWN_A : OWN_B;
                last   <= b_gnt;
                lock_q <= a_gnt ? a_lock : b_lock;
            end else begin
                state     <= IDLE;
                burst_cnt <= '0;
                lock_q    <= 1'b0;
            end
        end
    end

`ifdef DM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_gnt_cnt <= '0;
            b_gnt_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (a_gnt && a_gnt_cnt != 16'hFFFF) a_gnt_cnt <= a_gnt_cnt + 16'd1;
            if (b_gnt && b_gnt_cnt != 16'hFFFF) b_gnt_cnt <= b_gnt_cnt + 16'd1;
            if (((a_req & ~a_gnt) | (b_req & ~b_gnt)) && wait_cnt != 16'hFFFF)
                wait_cnt <= wait_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a behavioural single-port memory.
module tb_dm_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_wr, a_lock, b_req, b_wr, b_lock;
    logic [6:0]  a_addr, b_addr, m_addr;
    logic [31:0] a_wdata, b_wdata, m_wdata, m_rdata, a_rdata, b_rdata;
    logic        a_gnt, a_ack, b_gnt, b_ack, m_rd, m_wr;
`ifdef DM_ARB_PERF_EN
    logic [15:0] a_gnt_cnt, b_gnt_cnt, wait_cnt;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:127];

    always #5 clk = ~clk;

    always @(posedge clk) if (m_wr) mem[m_addr] <= m_wdata;
    assign m_rdata = m_wr ? m_wdata : mem[m_addr];

    dm_arbiter #(.AW(7), .DW(32), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
        .a_gnt(a_gnt), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
        .b_gnt(b_gnt), .b_ack(b_ack), .b_rdata(b_rdata),
        .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr), .m_wdata(m_wdata), .m_rdata(m_rdata)
`ifdef DM_ARB_PERF_EN
        , .a_gnt_cnt(a_gnt_cnt), .b_gnt_cnt(b_gnt_cnt), .wait_cnt(wait_cnt)
`endif
    );

    task automatic idle_inputs();
        a_req = 0; a_wr = 0; a_addr = '0; a_wdata = '0; a_lock = 0;
        b_req = 0; b_wr = 0; b_addr = '0; b_wdata = '0; b_lock = 0;
    endtask

    // Leaves the bench 1 time unit after a rising edge, reset released.
    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #2;
        a_req = 1; a_wr = 1; a_addr = 7'd3; a_wdata = 32'h12345678;
        @(posedge clk);
        #2;
        if (a_gnt !== 1'b0) begin failures++; $display("FAIL reset_a_gnt: got %b expected 0", a_gnt); end
        checks++;
        if (m_wr !== 1'b0 || m_rd !== 1'b0) begin failures++; $display("FAIL reset_mem_strobes: got rd=%b wr=%b expected 0 0", m_rd, m_wr); end
        checks++;
        if (a_ack !== 1'b0 || b_ack !== 1'b0) begin failures++; $display("FAIL reset_acks: got a=%b b=%b expected 0 0", a_ack, b_ack); end
        checks++;
        if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got a=%h b=%h expected 0 0", a_rdata, b_rdata); end
        checks++;
    endtask

    task automatic test_write_read();
        do_reset();
        a_req = 1; a_wr = 1; a_addr = 7'd5; a_wdata = 32'hDEADBEEF;
        #2;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin failures++; $display("FAIL wr_gnt: got a=%b b=%b expected 1 0", a_gnt, b_gnt); end
        checks++;
        if (m_wr !== 1'b1 || m_rd !== 1'b0 || m_addr !== 7'd5 || m_wdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL wr_mem_drive: got wr=%b rd=%b addr=%0d wdata=%h expected 1 0 5 deadbeef", m_wr, m_rd, m_addr, m_wdata);
        end
        checks++;
        @(posedge clk); #1;
        a_req = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
        if (a_ack !== 1'b1 || a_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_ack: got ack=%b rdata=%h expected 1 deadbeef", a_ack, a_rdata); end
        checks++;
        b_req = 1; b_wr = 0; b_addr = 7'd5;
        #2;
        if (b_gnt !== 1'b1 || m_rd !== 1'b1 || m_addr !== 7'd5) begin failures++; $display("FAIL rd_gnt: got gnt=%b rd=%b addr=%0d expected 1 1 5", b_gnt, m_rd, m_addr); end
        checks++;
        @(posedge clk); #1;
        b_req = 0; b_addr = '0;
        if (b_ack !== 1'b1 || b_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_ack: got ack=%b rdata=%h expected 1 deadbeef", b_ack, b_rdata); end
        checks++;
        if (a_ack !== 1'b0 || a_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL a_hold: got ack=%b rdata=%h expected 0 deadbeef", a_ack, a_rdata); end
        checks++;
    endtask

    // A writes addr 20+k, B reads back the word A wrote one cycle earlier.
    task automatic test_round_robin();
        int na, nb;
        logic exp_a;
        do_reset();
        na = 0; nb = 0;
        a_req = 1; a_wr = 1; a_addr = 7'd20; a_wdata = 32'h1000;
        b_req = 1; b_wr = 0; b_addr = 7'd20;
        for (int i = 0; i < 6; i++) begin
            exp_a = (i % 2 == 0);
            #2;
            if (a_gnt !== exp_a || b_gnt !== !exp_a) begin
                failures++; $display("FAIL rr_gnt cycle %0d: got a=%b b=%b expected a=%b b=%b", i, a_gnt, b_gnt, exp_a, !exp_a);
            end
            checks++;
            @(posedge clk); #1;
            if (a_ack !== exp_a || b_ack !== !exp_a) begin
                failures++; $display("FAIL rr_ack cycle %0d: got a=%b b=%b expected a=%b b=%b", i, a_ack, b_ack, exp_a, !exp_a);
            end
            checks++;
            if (exp_a) begin
                if (a_rdata !== 32'h1000 + na) begin failures++; $display("FAIL rr_a_rdata cycle %0d: got %h expected %h", i, a_rdata, 32'h1000 + na); end
                checks++;
                na++;
                a_addr = 7'(20 + na); a_wdata = 32'h1000 + na;
            end else begin
                if (b_rdata !== 32'h1000 + nb) begin failures++; $display("FAIL rr_raw_b_rdata cycle %0d: got %h expected %h", i, b_rdata, 32'h1000 + nb); end
                checks++;
                nb++;
                b_addr = 7'(20 + nb);
            end
        end
        idle_inputs();
        @(posedge clk); #1;
        if (a_ack !== 1'b0 || b_ack !== 1'b0) begin failures++; $display("FAIL rr_tail_ack: got a=%b b=%b expected 0 0", a_ack, b_ack); end
        checks++;
`ifdef DM_ARB_PERF_EN
        if (a_gnt_cnt !== 16'd3 || b_gnt_cnt !== 16'd3 || wait_cnt !== 16'd6) begin
            failures++; $display("FAIL perf_counts: got a=%0d b=%0d wait=%0d expected 3 3 6", a_gnt_cnt, b_gnt_cnt, wait_cnt);
        end
        checks++;
`endif
    endtask

    task automatic test_lock();
        logic [9:0] pat;
        pat = 10'b10_0001_0000;  // bit i set = B expected at cycle i
        do_reset();
        a_req = 1; a_lock = 1; b_req = 1;
        for (int i = 0; i < 10; i++) begin
            #2;
            if (b_gnt !== pat[i] || a_gnt !== !pat[i]) begin
                failures++; $display("FAIL lock_gnt cycle %0d: got a=%b b=%b expected a=%b b=%b", i, a_gnt, b_gnt, !pat[i], pat[i]);
            end
            checks++;
            @(posedge clk); #1;
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_b_burst();
        int acks;
        do_reset();
        acks = 0;
        b_req = 1; b_lock = 1; b_wr = 0; b_addr = 7'd20;
        for (int i = 0; i < 8; i++) begin
            #2;
            if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin failures++; $display("FAIL burst_gnt cycle %0d: got a=%b b=%b expected a=0 b=1", i, a_gnt, b_gnt); end
            checks++;
            @(posedge clk); #1;
            if (b_ack === 1'b1) acks++;
        end
        idle_inputs();
        if (acks != 8) begin failures++; $display("FAIL burst_acks: got %0d expected 8", acks); end
        checks++;
        if (b_rdata !== 32'h1000) begin failures++; $display("FAIL burst_rdata: got %h expected 00001000", b_rdata); end
        checks++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midcycle();
        do_reset();
        a_req = 1; a_wr = 1; a_addr = 7'd30; a_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        a_wdata = 32'h0BADF00D;
        #1;
        if (a_ack !== 1'b1 || m_wr !== 1'b1) begin failures++; $display("FAIL midrst_pre: got ack=%b wr=%b expected 1 1", a_ack, m_wr); end
        checks++;
        #1 rst_n = 0;
        #1;
        if (a_ack !== 1'b0 || a_rdata !== 32'h0 || m_wr !== 1'b0 || a_gnt !== 1'b0) begin
            failures++; $display("FAIL midrst_drop: got ack=%b rdata=%h wr=%b gnt=%b expected 0 0 0 0", a_ack, a_rdata, m_wr, a_gnt);
        end
        checks++;
        idle_inputs();
        @(posedge clk);
        #3 rst_n = 1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (a_ack !== 1'b0 || b_ack !== 1'b0) begin failures++; $display("FAIL midrst_stale_ack cycle %0d: got a=%b b=%b expected 0 0", i, a_ack, b_ack); end
            checks++;
        end
        if (mem[30] !== 32'hCAFEF00D) begin failures++; $display("FAIL midrst_mem: got %h expected cafef00d", mem[30]); end
        checks++;
        a_req = 1; b_req = 1;
        #2;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin failures++; $display("FAIL midrst_tie: got a=%b b=%b expected 1 0", a_gnt, b_gnt); end
        checks++;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_lock();
        test_b_burst();
        test_reset_midcycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
